hook_launch_ctrl: RTL

//  Parametrised hook/cable trajectory controller: integrates a fixed-point hook position once per frame

---
 rtl/hook_launch_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/hook_launch_ctrl.sv
// Hook/cable trajectory controller: integrates a fixed-point hook position once per frame (IDLE -> EXTEND -> RETRACT).
// Optional extend-length limit compiled in when HOOK_MAX_LENGTH_EN is defined.
module hook_launch_ctrl #(
    parameter int          INITIAL_X = 280,
    parameter int          INITIAL_Y = 185,
    parameter int unsigned FRAC_BITS = 6,
    parameter int          X_MIN     = 0,
    parameter int          X_MAX     = 639,
    parameter int          Y_MAX     = 479
`ifdef HOOK_MAX_LENGTH_EN
    ,
    parameter int          MAX_EXT_FRAMES = 64
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        launch,
    input  logic [11:0] launch_Xspeed,
    input  logic [11:0] launch_Yspeed,
    input  logic        collision,
    input  logic [1:0]  load_weight,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        busy,
    output logic        loaded,
    output logic        retract_done
);

    localparam int unsigned SW = 12;
    localparam int unsigned AW = 11 + FRAC_BITS + 1;

    localparam logic signed [AW-1:0] HOME_X = AW'(INITIAL_X * (1 << FRAC_BITS));
    localparam logic signed [AW-1:0] HOME_Y = AW'(INITIAL_Y * (1 << FRAC_BITS));
    // Crossing means the floor pixel leaves [X_MIN, X_MAX] / exceeds Y_MAX.
    localparam logic signed [AW-1:0] X_LO    = AW'(X_MIN * (1 << FRAC_BITS));
    localparam logic signed [AW-1:0] X_CLAMP = AW'(X_MAX * (1 << FRAC_BITS));
    localparam logic signed [AW-1:0] X_HI    = AW'((X_MAX + 1) * (1 << FRAC_BITS));
    localparam logic signed [AW-1:0] Y_CLAMP = AW'(Y_MAX * (1 << FRAC_BITS));
    localparam logic signed [AW-1:0] Y_HI    = AW'((Y_MAX + 1) * (1 << FRAC_BITS));

    typedef enum logic [1:0] {
        IDLE,
        EXTEND,
        RETRACT,
        RETRACT_LOADED
    } state_t;

    state_t                 state, state_n;
    logic signed [AW-1:0]   acc_x, acc_x_n, acc_y, acc_y_n;
    logic signed [AW-1:0]   vel_x, vel_x_n, vel_y, vel_y_n;
    logic signed [AW-1:0]   step_x, step_y;
    logic [1:0]             weight, weight_n;
    logic                   dom_x, dom_x_n;
    logic                   done, done_n;
    logic [SW-1:0]          abs_x, abs_y;
    logic                   hit;
    logic                   home_hit;

`ifdef HOOK_MAX_LENGTH_EN
    localparam int unsigned CW = $clog2(MAX_EXT_FRAMES + 1);
    logic [CW-1:0] ext_cnt, ext_cnt_n;
`endif

    // Loaded retract speed: reversed and divided by 2^w, never stalling a moving axis.
    function automatic logic signed [AW-1:0] loaded_vel(input logic signed [AW-1:0] v,
                                                         input logic [1:0] w);
        logic signed [AW-1:0] s;
        s = v >>> w;
        if (s == '0 && v != '0) begin
            s = v[AW-1] ? -AW'(1) : AW'(1);
        end
        return -s;
    endfunction

    always_comb begin
        state_n  = state;
        acc_x_n  = acc_x;
        acc_y_n  = acc_y;
        vel_x_n  = vel_x;
        vel_y_n  = vel_y;
        weight_n = weight;
        dom_x_n  = dom_x;
        done_n   = 1'b0;
        hit      = 1'b0;
        home_hit = 1'b0;
        step_x   = acc_x + vel_x;
        step_y   = acc_y + vel_y;
        abs_x    = launch_Xspeed[SW-1] ? (~launch_Xspeed + 12'd1) : launch_Xspeed;
        abs_y    = launch_Yspeed[SW-1] ? (~launch_Yspeed + 12'd1) : launch_Yspeed;
`ifdef HOOK_MAX_LENGTH_EN
        ext_cnt_n = ext_cnt;
`endif

        unique case (state)
            IDLE: begin
                if (launch && (launch_Xspeed != '0 || launch_Yspeed != '0)) begin
                    vel_x_n = {{(AW-SW){launch_Xspeed[SW-1]}}, launch_Xspeed};
                    vel_y_n = {{(AW-SW){launch_Yspeed[SW-1]}}, launch_Yspeed};
                    dom_x_n = (abs_x > abs_y);
                    state_n = EXTEND;
`ifdef HOOK_MAX_LENGTH_EN
                    ext_cnt_n = '0;
`endif
                end
            end

            EXTEND: begin
                if (startOfFrame) begin
                    acc_x_n = step_x;
                    acc_y_n = step_y;
`ifdef HOOK_MAX_LENGTH_EN
                    ext_cnt_n = ext_cnt + CW'(1);
`endif
                end
                // Collision wins over boundary clamp and length limit.
                if (collision) begin
                    weight_n = load_weight;
                    vel_x_n  = loaded_vel(vel_x, load_weight);
                    vel_y_n  = loaded_vel(vel_y, load_weight);
                    state_n  = RETRACT_LOADED;
                end else if (startOfFrame) begin
                    if (step_x < X_LO) begin
                        acc_x_n = X_LO;
                        hit     = 1'b1;
                    end else if (step_x >= X_HI) begin
                        acc_x_n = X_CLAMP;
                        hit     = 1'b1;
                    end
                    if (step_y >= Y_HI) begin
                        acc_y_n = Y_CLAMP;
                        hit     = 1'b1;
                    end
`ifdef HOOK_MAX_LENGTH_EN
                    if (ext_cnt_n == CW'(MAX_EXT_FRAMES)) begin
                        hit = 1'b1;
                    end
`endif
                    if (hit) begin
                        vel_x_n = -vel_x;
                        vel_y_n = -vel_y;
                        state_n = RETRACT;
                    end
                end
            end

            RETRACT, RETRACT_LOADED: begin
                if (startOfFrame) begin
                    acc_x_n = step_x;
                    acc_y_n = step_y;
                    if (dom_x) begin
                        home_hit = vel_x[AW-1] ? (step_x <= HOME_X) : (step_x >= HOME_X);
                    end else begin
                        home_hit = vel_y[AW-1] ? (step_y <= HOME_Y) : (step_y >= HOME_Y);
                    end
                    if (home_hit) begin
                        acc_x_n = HOME_X;
                        acc_y_n = HOME_Y;
                        vel_x_n = '0;
                        vel_y_n = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            acc_x  <= HOME_X;
            acc_y  <= HOME_Y;
            vel_x  <= '0;
            vel_y  <= '0;
            weight <= '0;
            dom_x  <= 1'b0;
            done   <= 1'b0;
`ifdef HOOK_MAX_LENGTH_EN
            ext_cnt <= '0;
`endif
        end else begin
            state  <= state_n;
            acc_x  <= acc_x_n;
            acc_y  <= acc_y_n;
            vel_x  <= vel_x_n;
            vel_y  <= vel_y_n;
            weight <= weight_n;
            dom_x  <= dom_x_n;
            done   <= done_n;
`ifdef HOOK_MAX_LENGTH_EN
            ext_cnt <= ext_cnt_n;
`endif
        end
    end

    // Floor pixel positions taken straight from the accumulators.
    assign topLeftX     = acc_x[FRAC_BITS+10:FRAC_BITS];
    assign topLeftY     = acc_y[FRAC_BITS+10:FRAC_BITS];
    assign busy         = (state != IDLE);
    assign loaded       = (state == RETRACT_LOADED);
    assign retract_done = done;

endmodule
